// File: rtl/seq_memory.sv
// Genius sequence store: appends RNG colours, replays them as timed LED pulses
// and checks the player's presses. Optional macro GENIUS_SPEEDUP_EN halves pulse timing on long sequences.
module seq_memory #(
    parameter int unsigned DATA_W      = 2,
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned ON_CYCLES   = 25_000_000,
    parameter int unsigned OFF_CYCLES  = 12_500_000,
    parameter int unsigned SPEEDUP_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_W-1:0]            rng_in,
    input  logic                         clear,
    input  logic                         append,
    input  logic                         play,
    input  logic                         user_valid,
    input  logic [DATA_W-1:0]            user_color,
    output logic                         play_valid,
    output logic [DATA_W-1:0]            play_color,
    output logic                         busy,
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic                         full,
    output logic                         check_ok,
    output logic                         check_err,
    output logic                         round_done
);

    localparam int unsigned LW   = $clog2(MAX_LEN + 1);
    localparam int unsigned PW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TW   = $clog2(MAXC + 1);

`ifdef GENIUS_SPEEDUP_EN
    localparam bit SPEEDUP_EN = 1'b1;
`else
    localparam bit SPEEDUP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHOW_ON, SHOW_OFF, WAIT_USER} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [MAX_LEN];
    logic [PW-1:0]       ptr;
    logic [TW-1:0]       timer;
    logic [TW-1:0]       on_last;
    logic [TW-1:0]       off_last;
    logic                wr_en;
    logic                ptr_last;

    assign busy     = (state != IDLE);
    assign full     = (len == LW'(MAX_LEN));
    assign ptr_last = (LW'(ptr) == len - LW'(1));
    assign wr_en    = (state == IDLE) && !clear && append && !full;

    // Sequence RAM carries no reset; only indices below len are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len[PW-1:0]] <= rng_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            ptr        <= '0;
            timer      <= '0;
            on_last    <= TW'(ON_CYCLES - 1);
            off_last   <= TW'(OFF_CYCLES - 1);
            play_valid <= 1'b0;
            play_color <= '0;
            check_ok   <= 1'b0;
            check_err  <= 1'b0;
            round_done <= 1'b0;
        end else begin
            check_ok   <= 1'b0;
            check_err  <= 1'b0;
            round_done <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                len        <= '0;
                ptr        <= '0;
                timer      <= '0;
                play_valid <= 1'b0;
                play_color <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (append) begin
                            if (!full) len <= len + LW'(1);
                        end else if (play && len != '0) begin
                            ptr        <= '0;
                            timer      <= '0;
                            state      <= SHOW_ON;
                            play_valid <= 1'b1;
                            play_color <= mem[0];
                            // Pulse timing is latched once for the whole playback.
                            if (SPEEDUP_EN && 32'(len) >= SPEEDUP_LEN) begin
                                on_last  <= TW'((ON_CYCLES >> 1) - 1);
                                off_last <= TW'((OFF_CYCLES >> 1) - 1);
                            end else begin
                                on_last  <= TW'(ON_CYCLES - 1);
                                off_last <= TW'(OFF_CYCLES - 1);
                            end
                        end
                    end
                    SHOW_ON: begin
                        if (timer == on_last) begin
                            timer      <= '0;
                            state      <= SHOW_OFF;
                            play_valid <= 1'b0;
                            play_color <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    SHOW_OFF: begin
                        if (timer == off_last) begin
                            timer <= '0;
                            if (ptr_last) begin
                                ptr   <= '0;
                                state <= WAIT_USER;
                            end else begin
                                ptr        <= ptr + PW'(1);
                                state      <= SHOW_ON;
                                play_valid <= 1'b1;
                                play_color <= mem[ptr + PW'(1)];
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    WAIT_USER: begin
                        if (user_valid) begin
                            if (user_color == mem[ptr]) begin
                                check_ok <= 1'b1;
                                if (ptr_last) begin
                                    round_done <= 1'b1;
                                    ptr        <= '0;
                                    state      <= IDLE;
                                end else begin
                                    ptr <= ptr + PW'(1);
                                end
                            end else begin
                                check_err <= 1'b1;
                                ptr       <= '0;
                                state     <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
